// File: rtl/riscv_branch_predictor_pkg.sv
// Shared constants and helpers for the RISC-V branch predictor: index mode selectors
// and the saturating 16-bit statistics increment.
package riscv_branch_predictor_pkg;

  localparam int unsigned BP_MODE_BIMODAL = 0;
  localparam int unsigned BP_MODE_GSHARE  = 1;

  localparam int unsigned STAT_W = 16;
  localparam logic [STAT_W-1:0] STAT_MAX = '1;

  // Saturating event counter step; holds once all ones is reached.
  function automatic logic [STAT_W-1:0] stat_bump(input logic [STAT_W-1:0] cnt,
                                                  input logic               en);
    return (en && (cnt != STAT_MAX)) ? cnt + STAT_W'(1) : cnt;
  endfunction

endpackage

// File: rtl/riscv_branch_predictor_sat_counter.sv
// Per-entry saturating direction counter. Reset leaves it weakly not-taken;
// init (allocation) forces weakly taken and wins over inc/dec.
module bp_sat_counter #(
  parameter int unsigned CTR_W = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic             dec,
  input  logic             init,
  output logic [CTR_W-1:0] value,
  output logic             msb
);

  localparam logic [CTR_W-1:0] CTR_MAX = '1;
  localparam logic [CTR_W-1:0] CTR_WNT = CTR_W'((1 << (CTR_W - 1)) - 1);
  localparam logic [CTR_W-1:0] CTR_WT  = CTR_W'(1 << (CTR_W - 1));

  logic [CTR_W-1:0] value_q;
  logic [CTR_W-1:0] value_d;

  always_comb begin
    value_d = value_q;
    if (init) begin
      value_d = CTR_WT;
    end else if (inc && !dec && (value_q != CTR_MAX)) begin
      value_d = value_q + CTR_W'(1);
    end else if (dec && !inc && (value_q != '0)) begin
      value_d = value_q - CTR_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      value_q <= CTR_WNT;
    end else begin
      value_q <= value_d;
    end
  end

  assign value = value_q;
  assign msb   = value_q[CTR_W-1];

endmodule

// File: rtl/riscv_branch_predictor.sv
// Tagged BTB plus saturating-counter direction predictor, bimodal or gshare indexed,
// with speculative global history, mispredict history repair and saturating stats.
module riscv_branch_predictor
  import riscv_branch_predictor_pkg::*;
#(
  parameter int unsigned ENTRIES = 16,
  parameter int unsigned CTR_W   = 2,
  parameter int unsigned TAG_W   = 8,
  parameter int unsigned GHR_W   = 4,
  parameter int unsigned MODE    = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [31:0]       lk_pc,
  input  logic              lk_valid,
  input  logic              lk_stall,
  output logic              pred_hit,
  output logic              pred_taken,
  output logic [31:0]       pred_target,
  output logic [GHR_W-1:0]  pred_ghr,
  input  logic              upd_valid,
  input  logic [31:0]       upd_pc,
  input  logic [GHR_W-1:0]  upd_ghr,
  input  logic              upd_taken,
  input  logic [31:0]       upd_target,
  input  logic              upd_mispredict,
  output logic [STAT_W-1:0] stat_lookups,
  output logic [STAT_W-1:0] stat_mispred
);

  localparam int unsigned IDX_W   = $clog2(ENTRIES);
  localparam int unsigned TAG_LO  = IDX_W + 1;
  localparam int unsigned TAG_HI  = IDX_W + TAG_W;
  localparam logic        GSHARE  = (MODE == BP_MODE_GSHARE);

  logic [ENTRIES-1:0]             valid_q;
  logic [TAG_W-1:0]               tag_q    [ENTRIES];
  logic [31:0]                    target_q [ENTRIES];
  logic [ENTRIES-1:0]             ctr_msb;
  logic [ENTRIES-1:0][CTR_W-1:0]  ctr_val;
  logic [GHR_W-1:0]               ghr_q;
  logic [GHR_W-1:0]               ghr_d;
  logic [STAT_W-1:0]              stat_lookups_q;
  logic [STAT_W-1:0]              stat_mispred_q;

  logic [IDX_W-1:0] lk_idx;
  logic [TAG_W-1:0] lk_tag;
  logic [IDX_W-1:0] upd_idx;
  logic [TAG_W-1:0] upd_tag;
  logic             upd_hit;
  logic             upd_alloc;
  logic             lk_adv;
  logic             repair;

  // gshare folds history into the low index bits; bimodal ignores it.
  assign lk_idx  = lk_pc[IDX_W:1]  ^ ({IDX_W{GSHARE}} & IDX_W'(ghr_q));
  assign upd_idx = upd_pc[IDX_W:1] ^ ({IDX_W{GSHARE}} & IDX_W'(upd_ghr));
  assign lk_tag  = lk_pc[TAG_HI:TAG_LO];
  assign upd_tag = upd_pc[TAG_HI:TAG_LO];

  assign pred_hit    = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
  assign pred_taken  = pred_hit && ctr_msb[lk_idx];
  assign pred_target = pred_hit ? target_q[lk_idx] : 32'h0;
  assign pred_ghr    = ghr_q;

  assign upd_hit   = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);
  assign upd_alloc = upd_valid && !upd_hit && upd_taken;
  assign lk_adv    = lk_valid && !lk_stall;
  assign repair    = upd_valid && upd_mispredict;

  for (genvar g = 0; g < ENTRIES; g++) begin : g_ctr
    logic sel;
    assign sel = upd_valid && (upd_idx == IDX_W'(g));
    bp_sat_counter #(.CTR_W(CTR_W)) u_ctr (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   (sel && upd_hit && upd_taken),
      .dec   (sel && upd_hit && !upd_taken),
      .init  (sel && !upd_hit && upd_taken),
      .value (ctr_val[g]),
      .msb   (ctr_msb[g])
    );
  end

  // Single write port: allocation writes tag/valid, any taken update rewrites target.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q <= '0;
      for (int i = 0; i < ENTRIES; i++) begin
        tag_q[i]    <= '0;
        target_q[i] <= '0;
      end
    end else begin
      if (upd_alloc) begin
        valid_q[upd_idx] <= 1'b1;
        tag_q[upd_idx]   <= upd_tag;
      end
      if (upd_valid && upd_taken) begin
        target_q[upd_idx] <= upd_target;
      end
    end
  end

  // Repair from the carried snapshot takes priority over the speculative shift.
  always_comb begin
    ghr_d = ghr_q;
    if (lk_adv && pred_hit) begin
      ghr_d = GHR_W'({ghr_q, pred_taken});
    end
    if (repair) begin
      ghr_d = GHR_W'({upd_ghr, upd_taken});
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ghr_q          <= '0;
      stat_lookups_q <= '0;
      stat_mispred_q <= '0;
    end else begin
      ghr_q          <= ghr_d;
      stat_lookups_q <= stat_bump(stat_lookups_q, lk_adv);
      stat_mispred_q <= stat_bump(stat_mispred_q, repair);
    end
  end

  assign stat_lookups = stat_lookups_q;
  assign stat_mispred = stat_mispred_q;

  logic unused_bits;
  assign unused_bits = ^{lk_pc, upd_pc, ctr_val};

endmodule

// File: tb/tb_riscv_branch_predictor.sv
// Directed bench for riscv_branch_predictor in gshare mode with default geometry.
module tb_riscv_branch_predictor;

  logic        clk;
  logic        rst_n;
  logic [31:0] lk_pc;
  logic        lk_valid;
  logic        lk_stall;
  logic        pred_hit;
  logic        pred_taken;
  logic [31:0] pred_target;
  logic [3:0]  pred_ghr;
  logic        upd_valid;
  logic [31:0] upd_pc;
  logic [3:0]  upd_ghr;
  logic        upd_taken;
  logic [31:0] upd_target;
  logic        upd_mispredict;
  logic [15:0] stat_lookups;
  logic [15:0] stat_mispred;

  int total = 0;
  int bad   = 0;

  riscv_branch_predictor #(
    .ENTRIES(16), .CTR_W(2), .TAG_W(8), .GHR_W(4), .MODE(1)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .lk_pc          (lk_pc),
    .lk_valid       (lk_valid),
    .lk_stall       (lk_stall),
    .pred_hit       (pred_hit),
    .pred_taken     (pred_taken),
    .pred_target    (pred_target),
    .pred_ghr       (pred_ghr),
    .upd_valid      (upd_valid),
    .upd_pc         (upd_pc),
    .upd_ghr        (upd_ghr),
    .upd_taken      (upd_taken),
    .upd_target     (upd_target),
    .upd_mispredict (upd_mispredict),
    .stat_lookups   (stat_lookups),
    .stat_mispred   (stat_mispred)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic upd(input logic [31:0] pc, input logic [3:0] ghr, input logic tkn,
                     input logic [31:0] tgt, input logic mis);
    upd_valid      = 1'b1;
    upd_pc         = pc;
    upd_ghr        = ghr;
    upd_taken      = tkn;
    upd_target     = tgt;
    upd_mispredict = mis;
  endtask

  initial begin
    logic exp_tk [4];
    rst_n = 1'b0; lk_pc = '0; lk_valid = 1'b0; lk_stall = 1'b0;
    upd_valid = 1'b0; upd_pc = '0; upd_ghr = '0; upd_taken = 1'b0;
    upd_target = '0; upd_mispredict = 1'b0;
    tick(); tick();
    rst_n = 1'b1;

    // Cold lookup misses; a miss does not shift history.
    lk_pc = 32'h100; lk_valid = 1'b1;
    #1;
    chk("reset_hit", 32'(pred_hit), 32'd0);
    chk("reset_taken", 32'(pred_taken), 32'd0);
    chk("reset_target", pred_target, 32'h0);
    chk("reset_ghr", 32'(pred_ghr), 32'd0);
    chk("reset_lookups", 32'(stat_lookups), 32'd0);
    chk("reset_mispred", 32'(stat_mispred), 32'd0);
    tick();
    lk_valid = 1'b0;
    chk("miss_lookups", 32'(stat_lookups), 32'd1);
    chk("miss_ghr", 32'(pred_ghr), 32'd0);

    // Allocate on taken miss; no same-cycle bypass.
    upd(32'h100, 4'b0000, 1'b1, 32'h80, 1'b0);
    #1;
    chk("nobypass_hit", 32'(pred_hit), 32'd0);
    tick();
    upd_valid = 1'b0;
    chk("alloc_hit", 32'(pred_hit), 32'd1);
    chk("alloc_taken", 32'(pred_taken), 32'd1);
    chk("alloc_target", pred_target, 32'h80);

    // Counter 2 -> 1 -> 0 -> 0 -> 0.
    for (int i = 0; i < 4; i++) begin
      upd(32'h100, 4'b0000, 1'b0, 32'hDEAD, 1'b0);
      tick();
      upd_valid = 1'b0;
      chk($sformatf("nt_taken%0d", i), 32'(pred_taken), 32'd0);
      chk($sformatf("nt_hit%0d", i), 32'(pred_hit), 32'd1);
    end
    chk("nt_target", pred_target, 32'h80);

    // Counter 0 -> 1 -> 2 -> 3 -> 3; last taken update moves target.
    exp_tk[0] = 1'b0; exp_tk[1] = 1'b1; exp_tk[2] = 1'b1; exp_tk[3] = 1'b1;
    for (int i = 0; i < 4; i++) begin
      upd(32'h100, 4'b0000, 1'b1, (i == 3) ? 32'h90 : 32'h80, 1'b0);
      tick();
      upd_valid = 1'b0;
      chk($sformatf("t_taken%0d", i), 32'(pred_taken), 32'(exp_tk[i]));
    end
    chk("t_target", pred_target, 32'h90);
    // Saturated at 3: two not-taken steps give 2 (taken) then 1 (not taken).
    upd(32'h100, 4'b0000, 1'b0, 32'h0, 1'b0);
    tick();
    chk("sat3_a", 32'(pred_taken), 32'd1);
    tick();
    upd_valid = 1'b0;
    chk("sat3_b", 32'(pred_taken), 32'd0);

    // gshare: same PC trained under two histories lands in different entries.
    upd(32'h204, 4'b0000, 1'b1, 32'h300, 1'b0);
    tick();
    upd(32'h204, 4'b1111, 1'b1, 32'h400, 1'b0);
    tick();
    upd(32'h204, 4'b1111, 1'b0, 32'h0, 1'b0);
    tick();
    upd_valid = 1'b0;
    lk_pc = 32'h204;
    #1;
    chk("gs0_hit", 32'(pred_hit), 32'd1);
    chk("gs0_taken", 32'(pred_taken), 32'd1);
    chk("gs0_target", pred_target, 32'h300);
    upd(32'h1000, 4'b0111, 1'b1, 32'h500, 1'b1);
    tick();
    upd_valid = 1'b0;
    chk("repair_ghr", 32'(pred_ghr), 32'b1111);
    chk("repair_mispred", 32'(stat_mispred), 32'd1);
    chk("gs15_hit", 32'(pred_hit), 32'd1);
    chk("gs15_taken", 32'(pred_taken), 32'd0);
    chk("gs15_target", pred_target, 32'h400);

    // Repair overrides a same-cycle advancing hit.
    lk_valid = 1'b1;
    upd(32'h1000, 4'b1010, 1'b1, 32'h600, 1'b1);
    #1;
    chk("pre_ovr_hit", 32'(pred_hit), 32'd1);
    tick();
    upd_valid = 1'b0; lk_valid = 1'b0;
    chk("ovr_ghr", 32'(pred_ghr), 32'b0101);
    chk("ovr_lookups", 32'(stat_lookups), 32'd2);
    chk("ovr_mispred", 32'(stat_mispred), 32'd2);

    // Stalled hit lookup: history and stats frozen, update still lands.
    lk_pc = 32'h1004; lk_valid = 1'b1; lk_stall = 1'b1;
    upd(32'h1004, 4'b0101, 1'b1, 32'h700, 1'b0);
    #1;
    chk("stall_hit", 32'(pred_hit), 32'd1);
    chk("stall_target_old", pred_target, 32'h500);
    tick();
    upd_valid = 1'b0;
    chk("stall_ghr", 32'(pred_ghr), 32'b0101);
    chk("stall_lookups", 32'(stat_lookups), 32'd2);
    chk("stall_target_new", pred_target, 32'h700);
    lk_stall = 1'b0;
    tick();
    lk_valid = 1'b0;
    chk("adv_ghr", 32'(pred_ghr), 32'b1011);
    chk("adv_lookups", 32'(stat_lookups), 32'd3);

    // upd_valid low: nothing moves.
    upd(32'h2000, 4'b1011, 1'b1, 32'h800, 1'b1);
    upd_valid = 1'b0;
    lk_pc = 32'h2000;
    tick();
    chk("noupd_mispred", 32'(stat_mispred), 32'd2);
    chk("noupd_ghr", 32'(pred_ghr), 32'b1011);
    chk("noupd_hit", 32'(pred_hit), 32'd0);

    // Drive stat_mispred to FFFE with not-taken misses, then saturate.
    upd(32'h3000, 4'b0011, 1'b0, 32'h0, 1'b1);
    repeat (65532) tick();
    chk("mis_fffe", 32'(stat_mispred), 32'h0000FFFE);
    tick();
    chk("mis_ffff", 32'(stat_mispred), 32'h0000FFFF);
    tick();
    upd_valid = 1'b0;
    chk("mis_hold", 32'(stat_mispred), 32'h0000FFFF);
    lk_pc = 32'h1002;
    #1;
    chk("pre_rst_ghr", 32'(pred_ghr), 32'b0110);
    chk("pre_rst_hit", 32'(pred_hit), 32'd1);
    chk("pre_rst_target", pred_target, 32'h700);

    // Mid-run reset clears everything.
    rst_n = 1'b0;
    tick();
    chk("rst_hit", 32'(pred_hit), 32'd0);
    chk("rst_taken", 32'(pred_taken), 32'd0);
    chk("rst_target", pred_target, 32'h0);
    chk("rst_ghr", 32'(pred_ghr), 32'd0);
    chk("rst_lookups", 32'(stat_lookups), 32'd0);
    chk("rst_mispred", 32'(stat_mispred), 32'd0);
    rst_n = 1'b1;
    lk_pc = 32'h100;
    tick();
    chk("post_rst_hit", 32'(pred_hit), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
